// File: rtl/tmr_alu_voter.sv
// Registered TMR majority voter for three ALU32 replicas. Votes on {carry, result}
// per valid sample, reports mismatch / uncorrectable, keeps saturating per-replica
// error counts and a per-replica health FSM that drops a persistently wrong
// replica from the voting set.
module tmr_alu_voter #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned FAULT_THRESH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] res_a,
  input  logic [WIDTH-1:0] res_b,
  input  logic [WIDTH-1:0] res_c,
  input  logic             cout_a,
  input  logic             cout_b,
  input  logic             cout_c,
  input  logic             clear_faults,
  output logic             out_valid,
  output logic [WIDTH-1:0] voted_result,
  output logic             voted_cout,
  output logic             mismatch,
  output logic             uncorrectable,
  output logic [CNT_W-1:0] err_cnt_a,
  output logic [CNT_W-1:0] err_cnt_b,
  output logic [CNT_W-1:0] err_cnt_c,
  output logic [2:0]       faulty
);

  localparam int unsigned WW     = WIDTH + 1;
  localparam logic [4:0]  Thresh = 5'(FAULT_THRESH);

  typedef enum logic [1:0] {StHealthy, StSuspect, StFaulty} health_e;

  logic [WW-1:0]    w [3];
  logic [WW-1:0]    maj;
  logic [WW-1:0]    voted;
  logic [2:0]       voting;
  logic [2:0]       dis;
  logic             unc;
  logic             mm;

  logic             out_valid_q, out_valid_d;
  logic [WW-1:0]    voted_q, voted_d;
  logic             mismatch_q, mismatch_d;
  logic             unc_q, unc_d;
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];
  health_e          state_q [3];
  health_e          state_d [3];
  logic [3:0]       consec_q [3];
  logic [3:0]       consec_d [3];
  logic [4:0]       consec_inc [3];

  assign w[0] = {cout_a, res_a};
  assign w[1] = {cout_b, res_b};
  assign w[2] = {cout_c, res_c};

  // Faulty flags decode straight from the registered health state.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      faulty[i] = (state_q[i] == StFaulty);
    end
  end

  // Vote among the non-faulty replicas; fall back to full majority when no
  // trustworthy majority exists.
  always_comb begin
    maj    = (w[0] & w[1]) | (w[0] & w[2]) | (w[1] & w[2]);
    voting = ~faulty;
    voted  = maj;
    unc    = 1'b0;
    case (voting)
      3'b111: unc = (w[0] != w[1]) && (w[0] != w[2]) && (w[1] != w[2]);
      3'b011: if (w[0] == w[1]) voted = w[0]; else unc = 1'b1;
      3'b101: if (w[0] == w[2]) voted = w[0]; else unc = 1'b1;
      3'b110: if (w[1] == w[2]) voted = w[1]; else unc = 1'b1;
      3'b001: voted = w[0];
      3'b010: voted = w[1];
      3'b100: voted = w[2];
      default: unc = 1'b1;
    endcase
    for (int i = 0; i < 3; i++) begin
      dis[i] = (w[i] != voted);
    end
    mm = (|(dis & voting)) | unc;
  end

  // Output register next state: outputs update only on valid samples, flags
  // drop to zero on idle cycles while the voted word holds.
  always_comb begin
    out_valid_d = in_valid;
    voted_d     = voted_q;
    mismatch_d  = 1'b0;
    unc_d       = 1'b0;
    if (in_valid) begin
      voted_d    = voted;
      mismatch_d = mm;
      unc_d      = unc;
    end
  end

  // Health FSMs and error counters; clear_faults beats any same-cycle disagreement.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      state_d[i]    = state_q[i];
      consec_d[i]   = consec_q[i];
      cnt_d[i]      = cnt_q[i];
      consec_inc[i] = {1'b0, consec_q[i]} + 5'd1;
      if (clear_faults) begin
        state_d[i]  = StHealthy;
        consec_d[i] = 4'd0;
        cnt_d[i]    = '0;
      end else if (in_valid) begin
        if (dis[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
        case (state_q[i])
          StHealthy: begin
            if (dis[i]) begin
              consec_d[i] = 4'd1;
              state_d[i]  = (Thresh <= 5'd1) ? StFaulty : StSuspect;
            end
          end
          StSuspect: begin
            if (dis[i]) begin
              consec_d[i] = consec_inc[i][3:0];
              if (consec_inc[i] >= Thresh) state_d[i] = StFaulty;
            end else begin
              consec_d[i] = 4'd0;
              state_d[i]  = StHealthy;
            end
          end
          StFaulty: ;
          default: begin
            state_d[i]  = StHealthy;
            consec_d[i] = 4'd0;
          end
        endcase
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      voted_q     <= '0;
      mismatch_q  <= 1'b0;
      unc_q       <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i]    <= '0;
        state_q[i]  <= StHealthy;
        consec_q[i] <= 4'd0;
      end
    end else begin
      out_valid_q <= out_valid_d;
      voted_q     <= voted_d;
      mismatch_q  <= mismatch_d;
      unc_q       <= unc_d;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i]    <= cnt_d[i];
        state_q[i]  <= state_d[i];
        consec_q[i] <= consec_d[i];
      end
    end
  end

  assign out_valid     = out_valid_q;
  assign voted_result  = voted_q[WIDTH-1:0];
  assign voted_cout    = voted_q[WIDTH];
  assign mismatch      = mismatch_q;
  assign uncorrectable = unc_q;
  assign err_cnt_a     = cnt_q[0];
  assign err_cnt_b     = cnt_q[1];
  assign err_cnt_c     = cnt_q[2];

endmodule
